// File: rtl/rng_game_core_pkg.sv
// Shared definitions for the random-number game: state encoding, the "no player"
// id and width helpers also used by the display mux and the UART message selector.
package rng_game_core_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_TURN    = 2'd1,
        ST_COMPARE = 2'd2,
        ST_DONE    = 2'd3
    } game_state_t;

    localparam int unsigned PLAYER_NONE = 0;

    // Bits needed for a player id 0..num_players, where 0 means nobody.
    function automatic int unsigned pid_width(input int unsigned num_players);
        return $clog2(num_players + 1);
    endfunction

    // Bits needed for a round-win count 0..rounds_to_win.
    function automatic int unsigned rounds_width(input int unsigned rounds_to_win);
        return $clog2(rounds_to_win + 1);
    endfunction

endpackage

// File: rtl/rng_argmax.sv
// Combinational unique-maximum finder: max_id_c is the 1-based id of the single
// holder of the largest value, or 0 when the maximum is shared.
module rng_argmax
    import rng_game_core_pkg::*;
#(
    parameter  int unsigned NUM_PLAYERS = 2,
    parameter  int unsigned RAND_W      = 8,
    localparam int unsigned PID_W       = pid_width(NUM_PLAYERS)
) (
    input  logic [NUM_PLAYERS*RAND_W-1:0] nums,
    output logic [PID_W-1:0]              max_id_c,
    output logic                          tie_c
);

    logic [RAND_W-1:0] max_v;
    logic [PID_W-1:0]  hits;

    always_comb begin
        max_v    = '0;
        hits     = '0;
        max_id_c = PID_W'(PLAYER_NONE);
        for (int i = 0; i < int'(NUM_PLAYERS); i++) begin
            if (nums[i*RAND_W +: RAND_W] > max_v) begin
                max_v = nums[i*RAND_W +: RAND_W];
            end
        end
        // A second pass counts holders of the maximum; more than one is a tie.
        for (int i = 0; i < int'(NUM_PLAYERS); i++) begin
            if (nums[i*RAND_W +: RAND_W] == max_v) begin
                hits     = hits + PID_W'(1);
                max_id_c = PID_W'(i + 1);
            end
        end
        tie_c = (hits > PID_W'(1));
        if (tie_c) begin
            max_id_c = PID_W'(PLAYER_NONE);
        end
    end

endmodule

// File: rtl/rng_game_core.sv
// N-player random-number game controller: players latch the LFSR in turn, the
// unique highest value wins the round, first to ROUNDS_TO_WIN wins the game.
module rng_game_core
    import rng_game_core_pkg::*;
#(
    parameter  int unsigned NUM_PLAYERS   = 2,
    parameter  int unsigned RAND_W        = 8,
    parameter  int unsigned ROUNDS_TO_WIN = 3,
    localparam int unsigned PID_W         = pid_width(NUM_PLAYERS),
    localparam int unsigned RW            = rounds_width(ROUNDS_TO_WIN)
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          start,
    input  logic [NUM_PLAYERS-1:0]        press,
    input  logic [RAND_W-1:0]             rand_value,
    output logic [NUM_PLAYERS*RAND_W-1:0] nums,
    output logic [NUM_PLAYERS*RW-1:0]     rounds,
    output logic [PID_W-1:0]              turn,
    output logic [PID_W-1:0]              round_winner,
    output logic [PID_W-1:0]              winner,
    output logic                          round_tick,
    output logic                          win_tick
);

    game_state_t                   state_q, state_d;
    logic [NUM_PLAYERS*RAND_W-1:0] nums_d;
    logic [NUM_PLAYERS*RW-1:0]     rounds_d;
    logic [PID_W-1:0]              turn_d, round_winner_d, winner_d;
    logic                          round_tick_d, win_tick_d;
    logic [PID_W-1:0]              max_id_c;
    logic                          tie_c;
    logic                          press_hit_c;
    logic [RW-1:0]                 win_count_c;

    rng_argmax #(
        .NUM_PLAYERS (NUM_PLAYERS),
        .RAND_W      (RAND_W)
    ) u_argmax (
        .nums     (nums),
        .max_id_c (max_id_c),
        .tie_c    (tie_c)
    );

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            nums         <= '0;
            rounds       <= '0;
            turn         <= '0;
            round_winner <= '0;
            winner       <= '0;
            round_tick   <= 1'b0;
            win_tick     <= 1'b0;
        end else begin
            state_q      <= state_d;
            nums         <= nums_d;
            rounds       <= rounds_d;
            turn         <= turn_d;
            round_winner <= round_winner_d;
            winner       <= winner_d;
            round_tick   <= round_tick_d;
            win_tick     <= win_tick_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d        = state_q;
        nums_d         = nums;
        rounds_d       = rounds;
        turn_d         = turn;
        round_winner_d = round_winner;
        winner_d       = winner;
        round_tick_d   = 1'b0;
        win_tick_d     = 1'b0;
        press_hit_c    = 1'b0;
        win_count_c    = '0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d        = ST_TURN;
                    nums_d         = '0;
                    rounds_d       = '0;
                    round_winner_d = PID_W'(PLAYER_NONE);
                    winner_d       = PID_W'(PLAYER_NONE);
                    turn_d         = PID_W'(1);
                end
            end

            ST_TURN: begin
                // Only the current player's button bit is looked at.
                for (int i = 0; i < int'(NUM_PLAYERS); i++) begin
                    if (turn == PID_W'(i + 1) && press[i]) begin
                        press_hit_c                = 1'b1;
                        nums_d[i*RAND_W +: RAND_W] = rand_value;
                    end
                end
                if (press_hit_c) begin
                    if (turn == PID_W'(NUM_PLAYERS)) begin
                        state_d      = ST_COMPARE;
                        turn_d       = '0;
                        round_tick_d = 1'b1;
                    end else begin
                        turn_d = turn + PID_W'(1);
                    end
                end
            end

            ST_COMPARE: begin
                round_winner_d = tie_c ? PID_W'(PLAYER_NONE) : max_id_c;
                state_d        = ST_TURN;
                turn_d         = PID_W'(1);
                if (!tie_c && max_id_c != PID_W'(PLAYER_NONE)) begin
                    for (int i = 0; i < int'(NUM_PLAYERS); i++) begin
                        if (max_id_c == PID_W'(i + 1)) begin
                            win_count_c = rounds[i*RW +: RW];
                            if (win_count_c < RW'(ROUNDS_TO_WIN)) begin
                                win_count_c = win_count_c + RW'(1);
                            end
                            rounds_d[i*RW +: RW] = win_count_c;
                        end
                    end
                    if (win_count_c == RW'(ROUNDS_TO_WIN)) begin
                        state_d    = ST_DONE;
                        winner_d   = max_id_c;
                        win_tick_d = 1'b1;
                        turn_d     = '0;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_rng_game_core.sv
// Self-checking bench for rng_game_core: a 3-player/2-round instance and an
// 8-player/1-round instance driven from vector tables, directed and random rounds.
module tb_rng_game_core;

    logic        clk;
    logic        reset_n;

    logic        start3;
    logic [2:0]  press3;
    logic [7:0]  rand3;
    logic [23:0] nums3;
    logic [5:0]  rounds3;
    logic [1:0]  turn3, rw3, win3;
    logic        rt3, wt3;

    logic        start8;
    logic [7:0]  press8;
    logic [7:0]  rand8;
    logic [63:0] nums8;
    logic [7:0]  rounds8;
    logic [3:0]  turn8, rw8, win8;
    logic        rt8, wt8;

    int n_tests = 0;
    int n_fail  = 0;

    rng_game_core #(.NUM_PLAYERS(3), .RAND_W(8), .ROUNDS_TO_WIN(2)) dut3 (
        .clk(clk), .reset_n(reset_n), .start(start3), .press(press3), .rand_value(rand3),
        .nums(nums3), .rounds(rounds3), .turn(turn3), .round_winner(rw3),
        .winner(win3), .round_tick(rt3), .win_tick(wt3)
    );

    rng_game_core #(.NUM_PLAYERS(8), .RAND_W(8), .ROUNDS_TO_WIN(1)) dut8 (
        .clk(clk), .reset_n(reset_n), .start(start8), .press(press8), .rand_value(rand8),
        .nums(nums8), .rounds(rounds8), .turn(turn8), .round_winner(rw8),
        .winner(win8), .round_tick(rt8), .win_tick(wt8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a, b, c;
        int         rw;
        logic [5:0] rounds;
        int         win;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start3_pulse();
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
    endtask

    task automatic press3_do(input int p, input logic [7:0] v);
        press3 = 3'(1 << (p - 1));
        rand3  = v;
        tick();
        press3 = '0;
    endtask

    // Reference: id of the sole holder of the largest value, 0 if shared.
    function automatic int unique_max(input int v[3]);
        int best = -1;
        int cnt  = 0;
        int id   = 0;
        foreach (v[j]) if (v[j] > best) best = v[j];
        foreach (v[j]) begin
            if (v[j] == best) begin
                cnt++;
                id = j + 1;
            end
        end
        return (cnt == 1) ? id : 0;
    endfunction

    task automatic play_round3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                               input int exp_rw, input logic [5:0] exp_rounds, input int exp_win);
        press3_do(1, a);
        check("turn_after_p1", 64'(turn3), 64'(2));
        check("nums_p1", 64'(nums3[7:0]), 64'(a));
        press3_do(2, b);
        check("turn_after_p2", 64'(turn3), 64'(3));
        press3_do(3, c);
        check("round_tick", 64'(rt3), 64'(1));
        check("turn_compare", 64'(turn3), 64'(0));
        check("nums_all", 64'(nums3), 64'({c, b, a}));
        tick();
        check("round_tick_clear", 64'(rt3), 64'(0));
        check("round_winner", 64'(rw3), 64'(exp_rw));
        check("rounds", 64'(rounds3), 64'(exp_rounds));
        check("winner", 64'(win3), 64'(exp_win));
        check("win_tick", 64'(wt3), 64'(exp_win != 0));
        check("turn_next", 64'(turn3), 64'((exp_win != 0) ? 0 : 1));
    endtask

    initial begin
        vec_t       vecs[6];
        int         rounds_m[3];
        int         vals[3];
        int         exp_id;
        int         exp_win;
        logic [5:0] exp_rounds;

        vecs[0] = '{8'd10,  8'd200, 8'd55,  2, 6'b00_01_00, 0};
        vecs[1] = '{8'd90,  8'd90,  8'd12,  0, 6'b00_01_00, 0};
        vecs[2] = '{8'd0,   8'd0,   8'd0,   0, 6'b00_01_00, 0};
        vecs[3] = '{8'd255, 8'd254, 8'd1,   1, 6'b00_01_01, 0};
        vecs[4] = '{8'd7,   8'd8,   8'd9,   3, 6'b01_01_01, 0};
        vecs[5] = '{8'd100, 8'd100, 8'd101, 3, 6'b10_01_01, 3};

        reset_n = 1'b0;
        start3 = 1'b0; press3 = '0; rand3 = '0;
        start8 = 1'b0; press8 = '0; rand8 = '0;
        #2;
        check("reset_turn", 64'(turn3), 64'(0));
        check("reset_nums", 64'(nums3), 64'(0));
        #5 reset_n = 1'b1;
        tick();

        // Presses in IDLE do nothing.
        press3_do(1, 8'd99);
        check("idle_press_turn", 64'(turn3), 64'(0));
        check("idle_press_nums", 64'(nums3), 64'(0));

        start3_pulse();
        check("start_turn", 64'(turn3), 64'(1));
        foreach (vecs[k]) begin
            play_round3(vecs[k].a, vecs[k].b, vecs[k].c, vecs[k].rw, vecs[k].rounds, vecs[k].win);
        end

        // DONE: presses ignored, win_tick does not repeat.
        press3 = 3'b111; rand3 = 8'd77;
        tick();
        press3 = '0;
        check("done_nums_hold", 64'(nums3), 64'({8'd101, 8'd100, 8'd100}));
        check("done_winner_hold", 64'(win3), 64'(3));
        check("done_win_tick_once", 64'(wt3), 64'(0));
        check("done_rounds_hold", 64'(rounds3), 64'(6'b10_01_01));
        check("done_turn", 64'(turn3), 64'(0));
        start3_pulse();
        check("restart_winner", 64'(win3), 64'(0));
        check("restart_turn", 64'(turn3), 64'(1));
        check("restart_rounds", 64'(rounds3), 64'(0));
        check("restart_nums", 64'(nums3), 64'(0));
        check("restart_rw", 64'(rw3), 64'(0));

        // Out-of-turn and simultaneous presses, start ignored in TURN and COMPARE.
        press3 = 3'b110; rand3 = 8'd33;
        tick();
        check("oot_turn", 64'(turn3), 64'(1));
        check("oot_nums", 64'(nums3), 64'(0));
        press3 = 3'b111; rand3 = 8'd44;
        tick();
        press3 = '0;
        check("simul_turn", 64'(turn3), 64'(2));
        check("simul_nums", 64'(nums3), 64'(24'd44));
        start3_pulse();
        check("turn_start_ignored", 64'(turn3), 64'(2));
        check("turn_start_nums", 64'(nums3), 64'(24'd44));
        press3_do(2, 8'd50);
        start3 = 1'b1;
        press3_do(3, 8'd60);
        check("cmp_entry_tick", 64'(rt3), 64'(1));
        tick();
        start3 = 1'b0;
        check("cmp_start_rw", 64'(rw3), 64'(3));
        check("cmp_start_rounds", 64'(rounds3), 64'(6'b01_00_00));
        check("cmp_start_turn", 64'(turn3), 64'(1));
        press3 = 3'b001;
        tick();
        press3 = '0;
        check("cmp_press_after", 64'(turn3), 64'(2));
        press3_do(2, 8'd1);
        press3 = 3'b100; rand3 = 8'd2;
        tick();
        press3 = 3'b111;
        tick();
        press3 = '0;
        // P1 kept 60 (rand3 at that press), P2=1, P3=2: P1 wins; COMPARE press ignored.
        check("cmp_press_ignored_turn", 64'(turn3), 64'(1));
        check("cmp_press_ignored_nums", 64'(nums3), 64'({8'd2, 8'd1, 8'd60}));
        check("cmp_press_rw", 64'(rw3), 64'(1));

        // Randomised rounds against the reference model.
        rounds_m = '{1, 0, 1};
        for (int k = 0; k < 30; k++) begin
            for (int j = 0; j < 3; j++) begin
                vals[j] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2))
                                                      : int'($urandom_range(0, 255));
            end
            exp_id  = unique_max(vals);
            exp_win = 0;
            if (exp_id != 0) begin
                rounds_m[exp_id-1]++;
                if (rounds_m[exp_id-1] == 2) exp_win = exp_id;
            end
            exp_rounds = {2'(rounds_m[2]), 2'(rounds_m[1]), 2'(rounds_m[0])};
            play_round3(8'(vals[0]), 8'(vals[1]), 8'(vals[2]), exp_id, exp_rounds, exp_win);
            if (exp_win != 0) begin
                start3_pulse();
                check("rand_restart_turn", 64'(turn3), 64'(1));
                rounds_m = '{0, 0, 0};
            end
        end

        // Asynchronous reset mid-TURN.
        press3_do(1, 8'd42);
        check("pre_reset_turn", 64'(turn3), 64'(2));
        #2 reset_n = 1'b0;
        #1;
        check("areset_nums", 64'(nums3), 64'(0));
        check("areset_rounds", 64'(rounds3), 64'(0));
        check("areset_turn", 64'(turn3), 64'(0));
        check("areset_rw", 64'(rw3), 64'(0));
        check("areset_winner", 64'(win3), 64'(0));
        check("areset_ticks", 64'({rt3, wt3}), 64'(0));
        reset_n = 1'b1;
        tick();
        press3_do(1, 8'd5);
        check("post_reset_idle", 64'(turn3), 64'(0));
        check("post_reset_nums", 64'(nums3), 64'(0));

        // Eight players, single round wins the game.
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        check("p8_start_turn", 64'(turn8), 64'(1));
        for (int p = 1; p <= 8; p++) begin
            press8 = 8'(1 << (p - 1));
            rand8  = (p == 8) ? 8'd250 : 8'(p * 20);
            tick();
            press8 = '0;
            if (p < 8) check("p8_turn", 64'(turn8), 64'(p + 1));
            if (p == 4) begin
                start8 = 1'b1;
                tick();
                start8 = 1'b0;
                check("p8_start_ignored", 64'(turn8), 64'(5));
            end
        end
        check("p8_round_tick", 64'(rt8), 64'(1));
        check("p8_nums", 64'(nums8), 64'({8'd250, 8'd140, 8'd120, 8'd100, 8'd80, 8'd60, 8'd40, 8'd20}));
        tick();
        check("p8_winner", 64'(win8), 64'(8));
        check("p8_win_tick", 64'(wt8), 64'(1));
        check("p8_rw", 64'(rw8), 64'(8));
        check("p8_rounds", 64'(rounds8), 64'(8'h80));
        check("p8_turn_done", 64'(turn8), 64'(0));
        tick();
        check("p8_win_tick_once", 64'(wt8), 64'(0));
        check("p8_winner_hold", 64'(win8), 64'(8));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rng_game_core.md
Name: rng_game_core

Overview:
- Parametrised successor of the two-player random-number game FSM.
- Supports N players and a configurable rounds-to-win target.
- Each player, in turn, latches the free-running LFSR value. The highest unique value wins the round; the first player to reach ROUNDS_TO_WIN wins the game.
- Sits between the button debouncers / LFSR and the display, RGB and UART logic of the game top level. It emits pulses for round and game events.

Parameters:
- NUM_PLAYERS, 2, number of players (2..8).
- RAND_W, 8, width of the random number and of the stored player numbers.
- ROUNDS_TO_WIN, 3, round wins needed to win the game (1..7).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse (debounced p_edge); starts or restarts a game
- press  in  NUM_PLAYERS  one-cycle pulses; bit i = player i+1 button
- rand  in  RAND_W  current LFSR value
- nums  out  NUM_PLAYERS*RAND_W  latched number per player; player i+1 at [i*RAND_W +: RAND_W]
- rounds  out  NUM_PLAYERS*RW  round wins per player; RW = $clog2(ROUNDS_TO_WIN+1)
- turn  out  PID_W  player whose turn it is, 1..N; 0 = nobody; PID_W = $clog2(NUM_PLAYERS+1)
- round_winner  out  PID_W  winner of the last compared round; 0 = tie or none
- winner  out  PID_W  game winner; 0 = game not finished
- round_tick  out  1  one-cycle pulse on each round evaluation
- win_tick  out  1  one-cycle pulse on entry to DONE

Behaviour:
- Clocking and reset:
  - All state updates on rising clk.
  - reset_n low asynchronously forces state IDLE and clears every output to 0 (nums, rounds, turn, round_winner, winner, both ticks).
  - Reset mid-game discards all progress.
- States: IDLE, TURN, COMPARE, DONE.
- IDLE:
  - turn = 0.
  - A start pulse clears nums, rounds, round_winner and winner, then enters TURN with turn = 1 on the next cycle.
- TURN:
  - press[turn-1] high at cycle t: at t+1, nums[turn] = rand sampled at t.
  - If turn < N, turn increments. If turn = N, state goes to COMPARE and turn = 0.
  - Presses from other players are ignored.
  - Simultaneous presses: only the current player's bit counts.
  - start is ignored in TURN.
- COMPARE (exactly 1 cycle):
  - Find the maximum over nums.
  - If exactly one player holds it: round_winner = that id and that player's rounds increments (saturating at ROUNDS_TO_WIN).
  - If the maximum is tied: round_winner = 0 and no increment.
  - round_tick pulses in this cycle.
  - Next state:
    - If the incremented count equals ROUNDS_TO_WIN: DONE, winner = id, win_tick pulses on the entry cycle.
    - Otherwise: TURN with turn = 1. nums are kept for display and are overwritten in turn order.
  - A press arriving during COMPARE is ignored.
- DONE:
  - winner, nums and rounds hold.
  - start behaves as in IDLE: clear everything, turn = 1, winner = 0.
  - press is ignored.
- Arithmetic and widths:
  - Comparison is unsigned.
  - Ties are resolved as "no winner", never by the lower index.
  - rounds never exceed ROUNDS_TO_WIN.
- Latency and pulse rules:
  - press to nums/turn update: 1 cycle.
  - Last press to round_tick: 1 cycle.
  - round_tick to win_tick: 1 cycle.
  - win_tick never repeats without a new game.

Decomposition:
- Shared game package/header holds:
  - state encoding localparams (IDLE=0, TURN=1, COMPARE=2, DONE=3);
  - the PLAYER_NONE = 0 constant;
  - PID_W/RW width helper functions, reused by the display mux and the UART message selector.
- One sub-module: rng_argmax. It is a combinational unique-maximum finder over NUM_PLAYERS x RAND_W, producing max_id (0 on tie) and a tie flag. It is instantiated once in COMPARE datapath logic.

Test Plan (NUM_PLAYERS=3, RAND_W=8, ROUNDS_TO_WIN=2 unless stated):
- Reset check: reset_n low mid-TURN -> all outputs 0 and state IDLE immediately, without waiting for a clock edge.
- Clean round: start; presses P1, P2, P3 with rand 8'd10, 8'd200, 8'd55 -> nums = {55,200,10}, round_tick one cycle after the P3 press, round_winner = 2, rounds[P2] = 1, turn returns to 1.
- Tie: a round with rand 8'd90, 8'd90, 8'd12 -> round_winner = 0, rounds unchanged, next round starts at turn = 1.
- Out-of-turn presses: during turn = 1, pulse press = 3'b110 then 3'b111 -> the first is ignored; the second latches only P1 and turn becomes 2.
- Game win: P3 wins two clean rounds -> win_tick one cycle after the second round_tick, winner = 3, rounds[P3] = 2; further presses change nothing; start clears winner and sets turn = 1.
- Parameter sweep: NUM_PLAYERS=8, ROUNDS_TO_WIN=1, 8 presses with P8 highest -> winner = 8 after the first round. Also check start pulses during TURN/COMPARE are ignored.
